// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter_pkg
// Brief   : Shared state encodings and constants for the data-memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

  // Ownership state of the shared data-memory port
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_OWN0    = 2'd1,
    ARB_OWN1_LK = 2'd2
  } arb_state_e;

  // Default address decoded as the GPO register
  localparam logic [9:0] DMEM_GPO_ADDR = 10'h050;

  // Bits needed to hold a counter value in the range 0..limit
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module  : arb_starve_ctr
// Brief   : Saturating anti-starvation counter with clear priority over
//           increment.
// Revision: 1.0 - initial release
// ============================================================================
module arb_starve_ctr #(
  parameter int LIMIT = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         sat;

  assign sat   = (cnt_q == W'(LIMIT));
  assign sat_o = sat;
  assign cnt_o = cnt_q;

  // Clear wins over increment; increment stops at LIMIT
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Two-master arbiter for the data memory port and GPO register.
//           M0 (load/store unit) has fixed priority; M1 (debug/loader) is
//           protected by an anti-starvation counter and may lock the port.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int                ADDR_W       = 10,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] GPO_ADDR     = ADDR_W'(DMEM_GPO_ADDR),
  parameter int                STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // master 0
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic [3:0]        m0_be_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  // master 1
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic [3:0]        m1_be_i,
  input  logic              m1_lock_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  // memory / GPO side
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_width_o,
  output logic              mem_write_o,
  output logic              gpo_write_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = cnt_width(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic              locked;
  logic              starve_sat;
  logic [CNT_W-1:0]  starve_cnt;
  logic              gnt0, gnt1, any_gnt;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [3:0]        win_be;
  logic              is_gpo;

  // Last command driven, so the memory bus is stable on idle cycles
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q,    be_d;

  // Read-return path per master
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q,  rdata0_d;
  logic [DATA_W-1:0] rdata1_q,  rdata1_d;

  assign locked = (state_q == ARB_OWN1_LK);

  // Grant selection; grants are held low for the whole reset assertion
  always_comb begin
    gnt1 = m1_req_i & (locked | ~m0_req_i | starve_sat);
    gnt0 = m0_req_i & ~locked & ~gnt1;
    gnt1 = gnt1 & rst_n;
    gnt0 = gnt0 & rst_n;
  end

  assign any_gnt  = gnt0 | gnt1;
  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  // Winner command mux and GPO address decode
  always_comb begin
    win_we    = gnt1 ? m1_we_i    : m0_we_i;
    win_addr  = gnt1 ? m1_addr_i  : m0_addr_i;
    win_wdata = gnt1 ? m1_wdata_i : m0_wdata_i;
    win_be    = gnt1 ? m1_be_i    : m0_be_i;
    is_gpo    = (win_addr == GPO_ADDR);
  end

  assign mem_addr_o  = any_gnt ? win_addr  : addr_q;
  assign mem_wdata_o = any_gnt ? win_wdata : wdata_q;
  assign mem_width_o = any_gnt ? win_be    : be_q;
  assign mem_write_o = any_gnt & win_we & ~is_gpo;
  assign gpo_write_o = any_gnt & win_we &  is_gpo;

  // Starvation counter: counts M0 wins while M1 waits, cleared when M1 wins or stops asking
  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT),
    .W     (CNT_W)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (gnt1 | ~m1_req_i),
    .inc_i (gnt0 & m1_req_i),
    .cnt_o (starve_cnt),
    .sat_o (starve_sat)
  );

  // Next ownership state; a lock is only released by m1_lock going low
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_OWN1_LK: begin
        if (!m1_lock_i) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        if (gnt1) begin
          state_d = m1_lock_i ? ARB_OWN1_LK : ARB_IDLE;
        end else if (gnt0) begin
          state_d = ARB_OWN0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
    endcase
  end

  // Next values for the held command and the read-return registers
  always_comb begin
    addr_d    = any_gnt ? win_addr  : addr_q;
    wdata_d   = any_gnt ? win_wdata : wdata_q;
    be_d      = any_gnt ? win_be    : be_q;
    rvalid0_d = gnt0 & ~m0_we_i;
    rvalid1_d = gnt1 & ~m1_we_i;
    rdata0_d  = rvalid0_d ? mem_rdata_i : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_rdata_i : rdata1_q;
  end

  // State, held command and read-return registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign m0_rvalid_o = rvalid0_q;
  assign m1_rvalid_o = rvalid1_q;
  assign m0_rdata_o  = rdata0_q;
  assign m1_rdata_o  = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Self-checking bench for dmem_arbiter with a read-data scoreboard,
//           a behavioural data memory and a GPO register.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [9:0]  m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_be = '0, m1_be = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_width;
  logic        mem_write, gpo_write;

  logic [31:0] mem [0:255];
  logic [7:0]  gpo = 8'h00;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(10), .DATA_W(32), .GPO_ADDR(10'h050), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_be_i(m0_be), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_be_i(m1_be), .m1_lock_i(m1_lock), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
    .m1_rdata_o(m1_rdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_width_o(mem_width),
    .mem_write_o(mem_write), .gpo_write_o(gpo_write), .mem_rdata_i(mem_rdata)
  );

  // Behavioural word memory, bit3 of the lane mask selects [31:24]
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_write) begin
      for (int l = 0; l < 4; l++)
        if (mem_width[l]) mem[mem_addr[9:2]][l*8 +: 8] <= mem_wdata[l*8 +: 8];
    end
    if (gpo_write) gpo <= mem_wdata[7:0];
  end

  // Scoreboard and protocol monitor
  always @(negedge clk) begin
    logic [31:0] exp;
    if (rst_n) begin
      if (m0_rvalid) begin
        checks++;
        if (q0.size() == 0) begin
          errors++; $display("FAIL m0_spurious_rvalid actual=1 required=0 t=%0t", $time);
        end else begin
          exp = q0.pop_front();
          if (m0_rdata !== exp) begin
            errors++; $display("FAIL m0_rdata actual=%h required=%h", m0_rdata, exp);
          end
        end
      end
      if (m1_rvalid) begin
        checks++;
        if (q1.size() == 0) begin
          errors++; $display("FAIL m1_spurious_rvalid actual=1 required=0 t=%0t", $time);
        end else begin
          exp = q1.pop_front();
          if (m1_rdata !== exp) begin
            errors++; $display("FAIL m1_rdata actual=%h required=%h", m1_rdata, exp);
          end
        end
      end
      checks++;
      if ((m0_gnt & m1_gnt) !== 1'b0) begin
        errors++; $display("FAIL both_gnt actual=%b%b required=not both", m0_gnt, m1_gnt);
      end
      checks++;
      if (((m0_gnt & ~m0_req) | (m1_gnt & ~m1_req)) !== 1'b0) begin
        errors++; $display("FAIL gnt_without_req gnt=%b%b req=%b%b", m0_gnt, m1_gnt, m0_req, m1_req);
      end
    end
  end

  // One M0 access; returns the write strobes seen in the granted cycle
  task automatic m0_access(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] exp_rdata,
                           output logic memw, output logic gpow);
    int  n = 0;
    logic got = 0;
    m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
    while (!got && n < 20) begin
      @(negedge clk);
      if (m0_gnt === 1'b1) got = 1;
      else begin @(posedge clk); #1; n++; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL m0_gnt_timeout actual=0 required=1"); end
    memw = mem_write; gpow = gpo_write;
    if (got && !we) q0.push_back(exp_rdata);
    @(posedge clk); #1;
    m0_req = 0;
    if (got && !we) begin
      @(negedge clk);
      checks++;
      if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL m0_rvalid_t1 actual=%b required=1", m0_rvalid); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL m0_rvalid_t2 actual=%b required=0", m0_rvalid); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #1;
    m0_req = 1; m0_we = 1; m0_addr = 10'h050; m1_req = 1; m1_we = 1;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, mem_write, gpo_write} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes actual=%b required=0000", {m0_gnt, m1_gnt, mem_write, gpo_write});
    end
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_read_regs rvalid=%b%b rdata0=%h rdata1=%h required=0", m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
    end
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_gpo();
    logic mw, gw;
    m0_access(1'b1, 10'h050, 32'h0000_00A5, 4'hF, 32'h0, mw, gw);
    checks++;
    if ({mw, gw} !== 2'b01) begin errors++; $display("FAIL gpo_strobes mem_write=%b gpo_write=%b required=0,1", mw, gw); end
    checks++;
    if (gpo !== 8'hA5) begin errors++; $display("FAIL gpo_value actual=%h required=a5", gpo); end
    checks++;
    if (mem[8'h14] !== 32'h1234_5678) begin errors++; $display("FAIL gpo_mem_untouched actual=%h required=12345678", mem[8'h14]); end
    m0_access(1'b0, 10'h050, 32'h0, 4'hF, 32'h1234_5678, mw, gw);
  endtask

  task automatic test_write_read();
    logic mw, gw;
    m0_access(1'b1, 10'h010, 32'hDEAD_BEEF, 4'hF, 32'h0, mw, gw);
    checks++;
    if ({mw, gw} !== 2'b10) begin errors++; $display("FAIL mem_strobes mem_write=%b gpo_write=%b required=1,0", mw, gw); end
    m0_access(1'b0, 10'h010, 32'h0, 4'hF, 32'hDEAD_BEEF, mw, gw);
  endtask

  task automatic test_byte_lane();
    logic mw, gw;
    m0_access(1'b1, 10'h020, 32'h1234_5678, 4'b0001, 32'h0, mw, gw);
    checks++;
    if (mem[8'h08] !== 32'hFFFF_FF78) begin errors++; $display("FAIL byte_lane actual=%h required=ffffff78", mem[8'h08]); end
    m0_access(1'b0, 10'h020, 32'h0, 4'hF, 32'hFFFF_FF78, mw, gw);
  endtask

  // Consecutive reads from both masters, one access per cycle
  task automatic test_back_to_back();
    m0_req = 1; m0_we = 0; m0_addr = 10'h010;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt0_a actual=%b required=1", m0_gnt); end
    q0.push_back(32'hDEAD_BEEF);
    @(posedge clk); #1;
    m0_addr = 10'h020;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt0_b actual=%b required=1", m0_gnt); end
    q0.push_back(32'hFFFF_FF78);
    @(posedge clk); #1;
    m0_req = 0; m1_req = 1; m1_we = 0; m1_addr = 10'h010;
    @(negedge clk);
    checks++;
    if (m1_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt1 actual=%b required=1", m1_gnt); end
    q1.push_back(32'hDEAD_BEEF);
    @(posedge clk); #1;
    m1_req = 0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL b2b_drain pending=%0d/%0d required=0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_starvation();
    m0_req = 1; m0_we = 1; m0_addr = 10'h100; m0_wdata = 32'h1; m0_be = 4'hF;
    m1_req = 1; m1_we = 1; m1_addr = 10'h104; m1_wdata = 32'h2; m1_be = 4'hF;
    for (int k = 0; k < 15; k++) begin
      logic exp1;
      exp1 = ((k % 5) == 4);
      @(negedge clk);
      checks++;
      if (m0_gnt !== ~exp1 || m1_gnt !== exp1) begin
        errors++; $display("FAIL starve_pattern k=%0d actual=%b%b required=%b%b", k, m0_gnt, m1_gnt, ~exp1, exp1);
      end
      @(posedge clk); #1;
    end
    m0_req = 0; m1_req = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_lock();
    m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 10'h200; m1_be = 4'hF;
    m0_we = 1; m0_addr = 10'h180; m0_wdata = 32'h5; m0_be = 4'hF;
    for (int b = 0; b < 8; b++) begin
      m1_wdata = 32'h100 + b;
      if (b == 7) m1_lock = 0;
      @(negedge clk);
      checks++;
      if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
        errors++; $display("FAIL lock_beat b=%0d gnt=%b%b required=01", b, m0_gnt, m1_gnt);
      end
      @(posedge clk); #1;
      m0_req = 1;
      if (b == 3) begin
        m1_req = 0;
        @(negedge clk);
        checks++;
        if (m1_gnt !== 1'b0 || m0_gnt !== 1'b0) begin
          errors++; $display("FAIL lock_holdoff gnt=%b%b required=00", m0_gnt, m1_gnt);
        end
        @(posedge clk); #1;
        m1_req = 1;
      end
    end
    m1_req = 0;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1) begin errors++; $display("FAIL lock_release_m0 actual=%b required=1", m0_gnt); end
    @(posedge clk); #1;
    m0_req = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_read();
    m0_req = 1; m0_we = 0; m0_addr = 10'h010;
    m1_req = 1; m1_we = 1; m1_addr = 10'h300; m1_lock = 0;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1) begin errors++; $display("FAIL rst_setup_gnt actual=%b required=1", m0_gnt); end
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0;
    checks++;
    if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL rst_setup_rvalid actual=%b required=1", m0_rvalid); end
    #1 rst_n = 0;
    #1;
    checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_mid_read rvalid=%b rdata=%h required=0/0", m0_rvalid, m0_rdata);
    end
    checks++;
    if (dut.state_q !== ARB_IDLE || dut.u_starve.cnt_q !== 3'd0) begin
      errors++; $display("FAIL rst_state state=%0d cnt=%0d required=0/0", dut.state_q, dut.u_starve.cnt_q);
    end
    m0_req = 1; m0_we = 1;
    #1;
    checks++;
    if (m0_gnt !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL rst_gnt_forced gnt=%b mem_write=%b required=0/0", m0_gnt, mem_write);
    end
    m0_req = 0; m0_we = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL rst_no_rvalid k=%0d actual=%b required=0", k, m0_rvalid); end
    end
    checks++;
    if (dut.state_q !== ARB_IDLE || dut.u_starve.cnt_q !== 3'd0) begin
      errors++; $display("FAIL rst_release_state state=%0d cnt=%0d required=0/0", dut.state_q, dut.u_starve.cnt_q);
    end
    @(posedge clk); #1;
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h14] = 32'h1234_5678;
    mem[8'h08] = 32'hFFFF_FFFF;
    test_reset();
    test_gpo();
    test_write_read();
    test_byte_lane();
    test_back_to_back();
    test_starvation();
    test_lock();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
